apb4_slave_regbank: RTL
=======================

// Module: apb4_slave_regbank
// PURPOSE
//  Parametrised APB4 completer: register bank with byte strobes, configurable wait states,
//  read-only register mask and PSLVERR generation. Next-generation DUT for the APB VIP:
//  exercises PREADY stretching, PSTRB and error responses. Registers drive fabric-side outputs.
// PARAMETERS
//  ADDR_WIDTH   8         PADDR width in bits
//  DATA_WIDTH   32        PWDATA/PRDATA width; must be 8, 16, 32 or 64
//  NUM_REGS     8         number of registers, 1..2**(ADDR_WIDTH-log2(DATA_WIDTH/8))
//  WAIT_STATES  2         PREADY-low cycles inserted per ACCESS phase, 0..15
//  RO_MASK      8'h80     bit i=1 -> register i read-only (write -> PSLVERR, no update)
//  RESET_VAL    0         reset value of every register
// PORTS
//  PCLK      in   1                    clock, all logic on rising edge
//  PRESET    in   1                    asynchronous active-high reset
//  PSEL      in   1                    completer select
//  PENABLE   in   1                    ACCESS-phase indicator
//  PWRITE    in   1                    1=write, 0=read
//  PADDR     in   ADDR_WIDTH           byte address
//  PWDATA    in   DATA_WIDTH           write data
//  PSTRB     in   DATA_WIDTH/8         write byte-lane enables
//  PPROT     in   3                    accepted, ignored
//  PRDATA    out  DATA_WIDTH           read data, valid only with PREADY=1 on a read
//  PREADY    out  1                    transfer completes this cycle
//  PSLVERR   out  1                    error response, valid only with PREADY=1
//  regs_o    out  NUM_REGS*DATA_WIDTH  flattened register contents, reg i at [i*DW +: DW]
//  err_cnt   out  8                    count of PSLVERR responses, saturates at 8'hFF
// BEHAVIOUR
//  Reset (async, any time): FSM->IDLE; PRDATA=0, PREADY=0, PSLVERR=0, regs=RESET_VAL,
//   err_cnt=0, wait counter=0. A transfer in flight is dropped; no register changes.
//  FSM IDLE/SETUP/ACCESS; PRDATA, PREADY, PSLVERR registered.
//   IDLE:   PSEL&!PENABLE -> SETUP. PSEL&PENABLE in IDLE is ignored (stays IDLE).
//   SETUP:  latch PADDR/PWRITE/PWDATA/PSTRB; decode; -> ACCESS.
//     WAIT_STATES=0: PREADY<=1 with PRDATA/PSLVERR at this edge (zero-wait ACCESS).
//     else: cnt<=WAIT_STATES, PREADY<=0.
//   ACCESS: cnt>1 -> cnt--; cnt==1 -> PREADY<=1 with PRDATA/PSLVERR, cnt<=0.
//     Cycle with PREADY=1: write committed at end of cycle; next PREADY<=0, PRDATA<=0,
//     PSLVERR<=0; -> SETUP if PSEL&!PENABLE else IDLE (back-to-back supported).
//     PSEL=0 while PREADY=0: abort, -> IDLE, no write, no err_cnt change.
//  Latency: completion ends WAIT_STATES+1 cycles after SETUP.
//  Decode: lanes=DATA_WIDTH/8; idx=PADDR>>log2(lanes); misaligned = PADDR[log2(lanes)-1:0]!=0.
//   Error if idx>=NUM_REGS, misaligned, or write to RO_MASK register. Write with PSTRB=0 is legal.
//   Error: no register update; PRDATA=0; PSLVERR=1; err_cnt+1 (saturating).
//  Write: byte lane b of reg[idx] updated only where PSTRB[b]=1; other lanes hold.
//  Read: PRDATA = reg[idx] sampled at PREADY-raising edge (RO registers readable).
//  PRDATA is 0 whenever PREADY=0 or PWRITE=1.
//  regs_o reflects a write the cycle after the completing ACCESS cycle.
// TESTING (defaults unless stated)
//  1. Write 0xDEADBEEF to 0x04, PSTRB=4'hF, then read 0x04 -> PREADY low 2 ACCESS
//     cycles then high; PRDATA=0xDEADBEEF, PSLVERR=0; regs_o[63:32]=0xDEADBEEF.
//  2. Reg 1=0xDEADBEEF; write 0x11223344 to 0x04, PSTRB=4'b0101 -> reg1=0xDE22BE44.
//  3. Write 0x1 to 0x1C (RO reg 7) -> PSLVERR=1, reg7 stays 0, err_cnt=1; read 0x20
//     (out of range) -> PSLVERR=1, PRDATA=0, err_cnt=2; read 0x05 (misaligned) -> err_cnt=3.
//  4. WAIT_STATES=0: back-to-back write 0x08 / read 0x08, no IDLE -> PREADY high each
//     first ACCESS cycle; read returns written data.
//  5. Assert PRESET during write ACCESS with cnt=1 -> PREADY/PSLVERR/PRDATA=0 at once,
//     target reg keeps RESET_VAL, FSM IDLE; next transfer completes normally.
//  6. Drop PSEL in first ACCESS of write to 0x0C -> no update, FSM IDLE, err_cnt unchanged.

Source files
------------

// File: rtl/apb4_slave_regbank.sv
// apb4_slave_regbank: APB4 completer fronting a byte-strobed register bank.
// Inserts a fixed number of PREADY-low cycles per transfer, flags read-only,
// out-of-range and misaligned accesses with PSLVERR, and counts the errors.
module apb4_slave_regbank #(
   parameter int unsigned           ADDR_WIDTH  = 8,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           NUM_REGS    = 8,
   parameter int unsigned           WAIT_STATES = 2,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = 8'h80,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic                           PCLK,
   input  logic                           PRESET,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   input  logic [DATA_WIDTH/8-1:0]        PSTRB,
   input  logic [2:0]                     PPROT,
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PREADY,
   output logic                           PSLVERR,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   output logic [7:0]                     err_cnt
);

   localparam int unsigned           LANES     = DATA_WIDTH / 8;
   localparam int unsigned           LANE_BITS = $clog2(LANES);
   localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << LANE_BITS) - 1);

   // The SETUP phase is recognised and decoded at the edge that closes it, so the
   // FSM only needs to remember whether an ACCESS phase is in progress.
   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic                  write_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [LANES-1:0]      strb_q;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic [ADDR_WIDTH-1:0] dec_idx;
   logic                  dec_err;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  commit;

   // Protection attributes are accepted but carry no meaning for this bank.
   logic unused_pprot;
   assign unused_pprot = ^PPROT;

   // Decode the live bus address: register index plus the three error causes.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      dec_idx = PADDR >> LANE_BITS;
      dec_err = ((PADDR & LANE_MASK) != '0) || (32'(dec_idx) >= NUM_REGS);
      for (int i = 0; i < NUM_REGS; i++) begin
         if (PWRITE && RO_MASK[i] && (dec_idx == ADDR_WIDTH'(i))) dec_err = 1'b1;
      end
   end

   // Read mux: live decode for the zero-wait path, latched index once in ACCESS.
   always_comb begin
      rd_idx  = (state_q == IDLE) ? dec_idx : idx_q;
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == ADDR_WIDTH'(i)) rd_data = regs[i];
      end
   end

   assign commit = (state_q == ACCESS) && PREADY && write_q && !err_q;

   // Transfer FSM: latches the request, counts wait states, drives the response.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         PRDATA  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         err_cnt <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         case (state_q)
            IDLE: begin
               if (PSEL && !PENABLE) begin
                  idx_q   <= dec_idx;
                  write_q <= PWRITE;
                  wdata_q <= PWDATA;
                  strb_q  <= PSTRB;
                  err_q   <= dec_err;
                  state_q <= ACCESS;
                  if (WAIT_STATES == 0) begin
                     PREADY  <= 1'b1;
                     PSLVERR <= dec_err;
                     PRDATA  <= (dec_err || PWRITE) ? '0 : rd_data;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= 4'(WAIT_STATES);
                  end
               end
            end
            ACCESS: begin
               if (PREADY) begin
                  // Completing cycle; a new SETUP is picked up from IDLE on the next edge.
                  if (err_q && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
                  PREADY  <= 1'b0;
                  PRDATA  <= '0;
                  PSLVERR <= 1'b0;
                  state_q <= IDLE;
               end else if (!PSEL) begin
                  // Requester abandoned the transfer: drop it without side effects.
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q > 4'd1) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  PREADY  <= 1'b1;
                  PSLVERR <= err_q;
                  PRDATA  <= (err_q || write_q) ? '0 : rd_data;
                  cnt_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Register bank: byte-lane update at the end of a completing, error-free write.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         // NOTE: the bank is built from flops that drive fabric outputs, so it is reset; a RAM would not be.
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else if (commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < LANES; b++) begin
               if ((idx_q == ADDR_WIDTH'(i)) && strb_q[b]) regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

endmodule
